arbitro_vc_pcie: RTL

- Round-robin arbiter and credit scheduler for the transaction layer's four virtual-channel (VC) FIFOs.
- Each cycle it picks at most one eligible VC, pops that FIFO and registers the word onto the shared output path.
- Per-VC credit counters throttle each VC against the receiver; a destination almost-full backpressures all VCs.
- Sits between the VC FIFOs and the downstream link FIFO in the transaction layer.

---
 rtl/arbitro_vc_pcie_if.sv | 33 +++
 rtl/arbitro_vc_pcie.sv | 135 +++++++++++++
 2 files changed

// File: rtl/arbitro_vc_pcie_if.sv
// rtl/arbitro_vc_pcie_if.sv - VC FIFO side and output path bundle for the VC arbiter
interface arbitro_vc_pcie_if #(
    parameter int NUM_VC     = 4,
    parameter int DATA_WIDTH = 10
);
    logic [NUM_VC-1:0]            vc_empty;
    logic [NUM_VC*DATA_WIDTH-1:0] vc_data;
    logic [NUM_VC-1:0]            credit_return;
    logic                         dst_almost_full;
    logic [NUM_VC-1:0]            vc_pop;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         valid_out;

    modport master (
        input  vc_empty,
        input  vc_data,
        input  credit_return,
        input  dst_almost_full,
        output vc_pop,
        output data_out,
        output valid_out
    );

    modport slave (
        output vc_empty,
        output vc_data,
        output credit_return,
        output dst_almost_full,
        input  vc_pop,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/arbitro_vc_pcie.sv
// rtl/arbitro_vc_pcie.sv - round-robin VC arbiter with per-VC credit throttling
module arbitro_vc_pcie #(
    parameter int NUM_VC     = 4,
    parameter int DATA_WIDTH = 10,
    parameter int CRED_WIDTH = 4,
    parameter int CRED_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    arbitro_vc_pcie_if.master     bus,
    output logic [2:0]            estado,
    output logic                  idle_out,
    output logic                  error_out
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [CRED_WIDTH-1:0] CMAX = CRED_WIDTH'(CRED_MAX);

    state_t                              state, next_state;
    logic [NUM_VC-1:0][CRED_WIDTH-1:0]   credit;
    logic [1:0]                          rr_ptr;
    logic [1:0]                          gnt_idx;
    logic [1:0]                          cand;
    logic                                gnt_valid;
    logic [3:0]                          elig;
    logic [3:0]                          pop;
    logic                                run;
    logic                                overflow;
    logic                                all_full_credit;

    assign run = (state == S_IDLE) || (state == S_ACTIVE);

    // init takes priority over arbitration, so it also masks eligibility
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = run && !init && !bus.vc_empty[i] &&
                      (credit[i] != '0) && !bus.dst_almost_full;
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_ptr;
        cand      = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!gnt_valid && elig[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign pop        = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
    assign bus.vc_pop = pop;

    // a simultaneous pop and return is net zero, so it never overflows
    always_comb begin
        overflow        = 1'b0;
        all_full_credit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (run && bus.credit_return[i] && !pop[i] && (credit[i] == CMAX))
                overflow = 1'b1;
            if (credit[i] != CMAX)
                all_full_credit = 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_INIT;
            S_INIT:   if (!init) next_state = S_IDLE;
            S_IDLE:   if (init) next_state = S_INIT;
                      else if (|elig) next_state = S_ACTIVE;
            S_ACTIVE: if (init) next_state = S_INIT;
                      else if (!(|elig)) next_state = S_IDLE;
            S_ERROR:  next_state = S_ERROR;
            default:  next_state = S_RESET;
        endcase
        if (overflow)
            next_state = S_ERROR;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            state <= S_RESET;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            credit <= '0;
        end else if (state == S_INIT) begin
            for (int i = 0; i < 4; i++)
                credit[i] <= CMAX;
        end else if (run) begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i] && !bus.credit_return[i])
                    credit[i] <= credit[i] - 1'b1;
                else if (bus.credit_return[i] && !pop[i] && (credit[i] != CMAX))
                    credit[i] <= credit[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr        <= 2'd3;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            idle_out      <= 1'b0;
            error_out     <= 1'b0;
        end else begin
            if (gnt_valid) begin
                rr_ptr       <= gnt_idx;
                bus.data_out <= bus.vc_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            bus.valid_out <= gnt_valid && !overflow;
            idle_out      <= (state == S_IDLE) && (&bus.vc_empty) && all_full_credit;
            error_out     <= (next_state == S_ERROR);
        end
    end

    assign estado = state;
endmodule
